// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: channel widths, response codes and the
// arbiter FSM state type.
package axi_lite_pkg;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_MASK_W = 4;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_RESP = 3'd4
   } arb_state_t;
endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle. Valid/ready rule on every channel: a beat transfers on a
// rising clk edge where valid && ready; the source holds valid and payload
// stable until then.
interface axi_lite_if;
   import axi_lite_pkg::*;

   logic                  awvalid;
   logic                  awready;
   logic [AXI_ADDR_W-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [AXI_DATA_W-1:0] wdata;
   logic [AXI_MASK_W-1:0] wmask;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [AXI_ADDR_W-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [AXI_DATA_W-1:0] rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wmask, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wmask, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request at or above
// i_ptr, wrapping around, returned as both one-hot and index.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);
   int            w_sum;
   logic [IW-1:0] w_cand;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_sum   = 0;
      w_cand  = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = int'(i_ptr) + k;
         if (w_sum >= N) w_sum = w_sum - N;
         w_cand = IW'(w_sum);
         if (!o_valid && i_req[w_cand]) begin
            o_valid         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end
endmodule

// File: rtl/axi_lite_arbiter.sv
// N-to-1 AXI4-Lite arbiter: one transaction at a time, round-robin between
// requesters, grant held from arbitration until the response handshake.
module axi_lite_arbiter
   import axi_lite_pkg::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input  logic       clk,
   input  logic       reset,
   axi_lite_if.slave  m [NUM_MASTERS],
   axi_lite_if.master s,
   output arb_state_t o_dbg_state
);
   localparam int GW = $clog2(NUM_MASTERS);

   arb_state_t    r_state, w_next_state;
   logic [GW-1:0] r_grant, w_next_grant;
   logic [GW-1:0] r_rr, w_next_rr, w_rr_inc;
   logic          r_aw_done, r_w_done, w_next_aw_done, w_next_w_done;
   logic          w_s_arvalid, w_s_rready, w_s_awvalid, w_s_wvalid, w_s_bready;
   logic          w_aw_hs, w_w_hs;

   logic [NUM_MASTERS-1:0] w_m_arvalid, w_m_awvalid, w_m_wvalid, w_m_rready, w_m_bready;
   logic [NUM_MASTERS-1:0] w_m_arready, w_m_rvalid, w_m_awready, w_m_wready, w_m_bvalid;
   logic [AXI_ADDR_W-1:0]  w_m_araddr [NUM_MASTERS];
   logic [AXI_ADDR_W-1:0]  w_m_awaddr [NUM_MASTERS];
   logic [AXI_DATA_W-1:0]  w_m_wdata  [NUM_MASTERS];
   logic [AXI_MASK_W-1:0]  w_m_wmask  [NUM_MASTERS];

   logic [NUM_MASTERS-1:0] w_gnt_onehot;
   logic [GW-1:0]          w_gnt_idx;
   logic                   w_gnt_valid;
   logic                   w_ar_pick;

   // Interface arrays need constant indices, so flatten them here.
   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_flat
      assign w_m_arvalid[i] = m[i].arvalid;
      assign w_m_awvalid[i] = m[i].awvalid;
      assign w_m_wvalid[i]  = m[i].wvalid;
      assign w_m_rready[i]  = m[i].rready;
      assign w_m_bready[i]  = m[i].bready;
      assign w_m_araddr[i]  = m[i].araddr;
      assign w_m_awaddr[i]  = m[i].awaddr;
      assign w_m_wdata[i]   = m[i].wdata;
      assign w_m_wmask[i]   = m[i].wmask;
      assign m[i].arready   = w_m_arready[i];
      assign m[i].rvalid    = w_m_rvalid[i];
      assign m[i].awready   = w_m_awready[i];
      assign m[i].wready    = w_m_wready[i];
      assign m[i].bvalid    = w_m_bvalid[i];
      assign m[i].rdata     = s.rdata;
      assign m[i].rresp     = s.rresp;
      assign m[i].bresp     = s.bresp;
   end

   rr_arbiter #(.N(NUM_MASTERS)) u_rr (
      .i_req   (w_m_arvalid | w_m_awvalid),
      .i_ptr   (r_rr),
      .o_grant (w_gnt_onehot),
      .o_idx   (w_gnt_idx),
      .o_valid (w_gnt_valid)
   );

   // Read takes precedence when the winner offers both AR and AW.
   assign w_ar_pick = |(w_gnt_onehot & w_m_arvalid);
   assign w_rr_inc  = (r_grant == GW'(NUM_MASTERS - 1)) ? '0 : r_grant + GW'(1);

   always_comb begin
      w_next_state   = r_state;
      w_next_grant   = r_grant;
      w_next_rr      = r_rr;
      w_next_aw_done = r_aw_done;
      w_next_w_done  = r_w_done;
      w_s_arvalid    = 1'b0;
      w_s_rready     = 1'b0;
      w_s_awvalid    = 1'b0;
      w_s_wvalid     = 1'b0;
      w_s_bready     = 1'b0;
      w_aw_hs        = 1'b0;
      w_w_hs         = 1'b0;
      w_m_arready    = '0;
      w_m_rvalid     = '0;
      w_m_awready    = '0;
      w_m_wready     = '0;
      w_m_bvalid     = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_valid) begin
               w_next_grant = w_gnt_idx;
               w_next_state = w_ar_pick ? ST_RD_ADDR : ST_WR_REQ;
            end
         end
         ST_RD_ADDR: begin
            w_s_arvalid          = w_m_arvalid[r_grant];
            w_m_arready[r_grant] = s.arready;
            if (w_s_arvalid && s.arready) w_next_state = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            w_m_rvalid[r_grant] = s.rvalid;
            w_s_rready          = w_m_rready[r_grant];
            if (s.rvalid && w_s_rready) begin
               w_next_state = ST_IDLE;
               w_next_rr    = w_rr_inc;
            end
         end
         ST_WR_REQ: begin
            w_s_awvalid          = w_m_awvalid[r_grant] && !r_aw_done;
            w_s_wvalid           = w_m_wvalid[r_grant] && !r_w_done;
            w_m_awready[r_grant] = s.awready && !r_aw_done;
            w_m_wready[r_grant]  = s.wready && !r_w_done;
            w_aw_hs              = w_s_awvalid && s.awready;
            w_w_hs               = w_s_wvalid && s.wready;
            if (w_aw_hs) w_next_aw_done = 1'b1;
            if (w_w_hs)  w_next_w_done  = 1'b1;
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
               w_next_state   = ST_WR_RESP;
               w_next_aw_done = 1'b0;
               w_next_w_done  = 1'b0;
            end
         end
         ST_WR_RESP: begin
            w_m_bvalid[r_grant] = s.bvalid;
            w_s_bready          = w_m_bready[r_grant];
            if (s.bvalid && w_s_bready) begin
               w_next_state = ST_IDLE;
               w_next_rr    = w_rr_inc;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_rr      <= '0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_grant   <= w_next_grant;
         r_rr      <= w_next_rr;
         r_aw_done <= w_next_aw_done;
         r_w_done  <= w_next_w_done;
      end
   end

   assign s.arvalid   = w_s_arvalid;
   assign s.araddr    = w_m_araddr[r_grant];
   assign s.rready    = w_s_rready;
   assign s.awvalid   = w_s_awvalid;
   assign s.awaddr    = w_m_awaddr[r_grant];
   assign s.wvalid    = w_s_wvalid;
   assign s.wdata     = w_m_wdata[r_grant];
   assign s.wmask     = w_m_wmask[r_grant];
   assign s.bready    = w_s_bready;
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with two masters; the bench plays both
// the requesters and the downstream slave.
module tb_axi_lite_arbiter;
   import axi_lite_pkg::*;

   logic       clk;
   logic       reset;
   arb_state_t dut_state;

   axi_lite_if m_if [2] ();
   axi_lite_if s_if ();

   logic [1:0]  tb_arvalid, tb_awvalid, tb_wvalid, tb_rready, tb_bready;
   logic [31:0] tb_araddr [2];
   logic [31:0] tb_awaddr [2];
   logic [31:0] tb_wdata  [2];
   logic [3:0]  tb_wmask  [2];
   logic [1:0]  ob_arready, ob_rvalid, ob_awready, ob_wready, ob_bvalid;
   logic [31:0] ob_rdata [2];
   logic [1:0]  ob_rresp [2];
   logic [1:0]  ob_bresp [2];

   logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp, s_bresp;

   int checks = 0;
   int errors = 0;
   int aw_cnt = 0;
   int w_cnt  = 0;
   int aw_base, w_base;

   for (genvar gi = 0; gi < 2; gi++) begin : g_m
      assign m_if[gi].arvalid = tb_arvalid[gi];
      assign m_if[gi].araddr  = tb_araddr[gi];
      assign m_if[gi].awvalid = tb_awvalid[gi];
      assign m_if[gi].awaddr  = tb_awaddr[gi];
      assign m_if[gi].wvalid  = tb_wvalid[gi];
      assign m_if[gi].wdata   = tb_wdata[gi];
      assign m_if[gi].wmask   = tb_wmask[gi];
      assign m_if[gi].rready  = tb_rready[gi];
      assign m_if[gi].bready  = tb_bready[gi];
      assign ob_arready[gi]   = m_if[gi].arready;
      assign ob_rvalid[gi]    = m_if[gi].rvalid;
      assign ob_awready[gi]   = m_if[gi].awready;
      assign ob_wready[gi]    = m_if[gi].wready;
      assign ob_bvalid[gi]    = m_if[gi].bvalid;
      assign ob_rdata[gi]     = m_if[gi].rdata;
      assign ob_rresp[gi]     = m_if[gi].rresp;
      assign ob_bresp[gi]     = m_if[gi].bresp;
   end

   assign s_if.arready = s_arready;
   assign s_if.awready = s_awready;
   assign s_if.wready  = s_wready;
   assign s_if.rvalid  = s_rvalid;
   assign s_if.rdata   = s_rdata;
   assign s_if.rresp   = s_rresp;
   assign s_if.bvalid  = s_bvalid;
   assign s_if.bresp   = s_bresp;

   axi_lite_arbiter #(.NUM_MASTERS(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .m           (m_if),
      .s           (s_if),
      .o_dbg_state (dut_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (s_if.awvalid && s_if.awready) aw_cnt <= aw_cnt + 1;
      if (s_if.wvalid && s_if.wready)   w_cnt  <= w_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle with the requester's AR already presented.
   task automatic serve_read(input int mi, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, input int waits);
      int oi;
      oi = 1 - mi;
      #1 chk("rd_bubble_arvalid", 32'(s_if.arvalid), 32'd0);
      step();
      chk("rd_state_addr", 32'(dut_state), 32'(ST_RD_ADDR));
      chk("rd_s_arvalid", 32'(s_if.arvalid), 32'd1);
      chk("rd_s_araddr", s_if.araddr, addr);
      chk("rd_no_aw", 32'(s_if.awvalid), 32'd0);
      s_arready = 1'b1;
      #1;
      chk("rd_arready_g", 32'(ob_arready[mi]), 32'd1);
      chk("rd_arready_o", 32'(ob_arready[oi]), 32'd0);
      step();
      tb_arvalid[mi] = 1'b0;
      s_arready      = 1'b0;
      chk("rd_state_data", 32'(dut_state), 32'(ST_RD_DATA));
      chk("rd_s_rready", 32'(s_if.rready), 32'd1);
      for (int k = 0; k < waits; k++) begin
         chk("rd_wait_rvalid", 32'(ob_rvalid), 32'd0);
         step();
      end
      s_rvalid = 1'b1;
      s_rdata  = data;
      s_rresp  = resp;
      #1;
      chk("rd_rvalid_g", 32'(ob_rvalid[mi]), 32'd1);
      chk("rd_rvalid_o", 32'(ob_rvalid[oi]), 32'd0);
      chk("rd_rdata", ob_rdata[mi], data);
      chk("rd_rresp", 32'(ob_rresp[mi]), 32'(resp));
      step();
      s_rvalid = 1'b0;
      chk("rd_state_idle", 32'(dut_state), 32'(ST_IDLE));
   endtask

   // Called in an IDLE cycle with the requester's AW and W already presented.
   task automatic serve_write(input int mi, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] mask, input logic [1:0] resp, input int waits);
      int oi;
      oi = 1 - mi;
      aw_base = aw_cnt;
      w_base  = w_cnt;
      #1 chk("wr_bubble_awvalid", 32'(s_if.awvalid), 32'd0);
      step();
      chk("wr_state_req", 32'(dut_state), 32'(ST_WR_REQ));
      chk("wr_s_awvalid", 32'(s_if.awvalid), 32'd1);
      chk("wr_s_wvalid", 32'(s_if.wvalid), 32'd1);
      chk("wr_s_awaddr", s_if.awaddr, addr);
      chk("wr_s_wdata", s_if.wdata, data);
      chk("wr_s_wmask", 32'(s_if.wmask), 32'(mask));
      s_awready = 1'b1;
      s_wready  = 1'b1;
      #1;
      chk("wr_awready_g", 32'(ob_awready[mi]), 32'd1);
      chk("wr_wready_g", 32'(ob_wready[mi]), 32'd1);
      chk("wr_awready_o", 32'(ob_awready[oi]), 32'd0);
      step();
      tb_awvalid[mi] = 1'b0;
      tb_wvalid[mi]  = 1'b0;
      s_awready      = 1'b0;
      s_wready       = 1'b0;
      chk("wr_state_resp", 32'(dut_state), 32'(ST_WR_RESP));
      chk("wr_s_bready", 32'(s_if.bready), 32'd1);
      for (int k = 0; k < waits; k++) begin
         chk("wr_wait_state", 32'(dut_state), 32'(ST_WR_RESP));
         chk("wr_wait_arvalid", 32'(s_if.arvalid), 32'd0);
         chk("wr_wait_arready", 32'(ob_arready), 32'd0);
         step();
      end
      s_bvalid = 1'b1;
      s_bresp  = resp;
      #1;
      chk("wr_bvalid_g", 32'(ob_bvalid[mi]), 32'd1);
      chk("wr_bvalid_o", 32'(ob_bvalid[oi]), 32'd0);
      chk("wr_bresp", 32'(ob_bresp[mi]), 32'(resp));
      step();
      s_bvalid = 1'b0;
      chk("wr_state_idle", 32'(dut_state), 32'(ST_IDLE));
      chk("wr_aw_count", 32'(aw_cnt - aw_base), 32'd1);
      chk("wr_w_count", 32'(w_cnt - w_base), 32'd1);
   endtask

   initial begin
      reset      = 1'b1;
      tb_arvalid = '0;
      tb_awvalid = '0;
      tb_wvalid  = '0;
      tb_rready  = 2'b11;
      tb_bready  = 2'b11;
      tb_araddr[0] = 32'h0;        tb_araddr[1] = 32'h0;
      tb_awaddr[0] = 32'h1234_5670; tb_awaddr[1] = 32'h9ABC_DEF0;
      tb_wdata[0]  = 32'h0000_00AA; tb_wdata[1]  = 32'h0000_00BB;
      tb_wmask[0]  = 4'h5;          tb_wmask[1]  = 4'hA;
      s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
      s_rvalid  = 1'b0; s_bvalid  = 1'b0;
      s_rdata   = 32'h0; s_rresp = AXI_RESP_OKAY; s_bresp = AXI_RESP_OKAY;
      repeat (2) step();

      // Reset state: idle, all handshakes low, payload muxed from m[0].
      chk("rst_state", 32'(dut_state), 32'(ST_IDLE));
      chk("rst_s_valids", 32'({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready}), 32'd0);
      chk("rst_m_outs", 32'({ob_arready, ob_rvalid, ob_awready, ob_wready, ob_bvalid}), 32'd0);
      chk("rst_awaddr_m0", s_if.awaddr, 32'h1234_5670);
      chk("rst_wdata_m0", s_if.wdata, 32'h0000_00AA);
      reset = 1'b0;
      step();

      // Single read from m[0] with two slave wait cycles.
      tb_arvalid[0] = 1'b1;
      tb_araddr[0]  = 32'h8000_0000;
      serve_read(0, 32'h8000_0000, 32'hDEAD_BEEF, AXI_RESP_OKAY, 2);

      // Contested reads from a fresh reset: order m0, m1, m0, m1.
      reset = 1'b1;
      step();
      reset = 1'b0;
      tb_arvalid   = 2'b11;
      tb_araddr[0] = 32'h0000_1000;
      tb_araddr[1] = 32'h0000_2000;
      serve_read(0, 32'h0000_1000, 32'h1111_1111, AXI_RESP_OKAY, 0);
      tb_arvalid[0] = 1'b1;
      tb_araddr[0]  = 32'h0000_1004;
      serve_read(1, 32'h0000_2000, 32'h2222_2222, AXI_RESP_OKAY, 0);
      tb_arvalid[1] = 1'b1;
      tb_araddr[1]  = 32'h0000_2004;
      serve_read(0, 32'h0000_1004, 32'h3333_3333, AXI_RESP_OKAY, 0);
      serve_read(1, 32'h0000_2004, 32'h4444_4444, AXI_RESP_OKAY, 0);

      // m[1] write with W presented two cycles before AW.
      tb_wvalid[1] = 1'b1;
      tb_wdata[1]  = 32'h0000_0041;
      tb_wmask[1]  = 4'h1;
      tb_awaddr[1] = 32'hA000_03F8;
      aw_base = aw_cnt;
      w_base  = w_cnt;
      step();
      chk("wfirst_state_idle", 32'(dut_state), 32'(ST_IDLE));
      chk("wfirst_s_wvalid", 32'(s_if.wvalid), 32'd0);
      step();
      tb_awvalid[1] = 1'b1;
      #1 chk("wfirst_bubble", 32'(s_if.awvalid), 32'd0);
      step();
      chk("wfirst_state_req", 32'(dut_state), 32'(ST_WR_REQ));
      s_wready = 1'b1;
      #1;
      chk("wfirst_s_wvalid1", 32'(s_if.wvalid), 32'd1);
      chk("wfirst_s_wdata", s_if.wdata, 32'h0000_0041);
      chk("wfirst_s_wmask", 32'(s_if.wmask), 32'h1);
      chk("wfirst_s_awaddr", s_if.awaddr, 32'hA000_03F8);
      chk("wfirst_wready", 32'(ob_wready), 32'b10);
      step();
      tb_wvalid[1] = 1'b0;
      s_awready    = 1'b1;
      #1;
      chk("wfirst_wvalid_done", 32'(s_if.wvalid), 32'd0);
      chk("wfirst_wready_done", 32'(ob_wready), 32'd0);
      chk("wfirst_awready", 32'(ob_awready), 32'b10);
      step();
      tb_awvalid[1] = 1'b0;
      s_awready     = 1'b0;
      s_wready      = 1'b0;
      chk("wfirst_state_resp", 32'(dut_state), 32'(ST_WR_RESP));
      s_bvalid = 1'b1;
      s_bresp  = AXI_RESP_SLVERR;
      #1;
      chk("wfirst_bvalid", 32'(ob_bvalid), 32'b10);
      chk("wfirst_bresp_bcast", 32'(ob_bresp[0]), 32'(AXI_RESP_SLVERR));
      step();
      s_bvalid = 1'b0;
      chk("wfirst_state_idle2", 32'(dut_state), 32'(ST_IDLE));
      chk("wfirst_aw_count", 32'(aw_cnt - aw_base), 32'd1);
      chk("wfirst_w_count", 32'(w_cnt - w_base), 32'd1);

      // m[0] with AR and AW together: read completes before AW is forwarded.
      tb_arvalid[0] = 1'b1;
      tb_araddr[0]  = 32'h0000_3000;
      tb_awvalid[0] = 1'b1;
      tb_awaddr[0]  = 32'h0000_4000;
      tb_wvalid[0]  = 1'b1;
      tb_wdata[0]   = 32'h5555_AAAA;
      tb_wmask[0]   = 4'hF;
      serve_read(0, 32'h0000_3000, 32'h0000_0077, AXI_RESP_OKAY, 1);
      serve_write(0, 32'h0000_4000, 32'h5555_AAAA, 4'hF, AXI_RESP_OKAY, 0);

      // m[1] write with bvalid held off 10 cycles while m[0] read waits.
      tb_awvalid[1] = 1'b1;
      tb_awaddr[1]  = 32'h0000_5000;
      tb_wvalid[1]  = 1'b1;
      tb_wdata[1]   = 32'h0BAD_F00D;
      tb_wmask[1]   = 4'h3;
      tb_arvalid[0] = 1'b1;
      tb_araddr[0]  = 32'h0000_6000;
      serve_write(1, 32'h0000_5000, 32'h0BAD_F00D, 4'h3, AXI_RESP_OKAY, 10);
      serve_read(0, 32'h0000_6000, 32'hCAFE_0001, AXI_RESP_SLVERR, 0);

      // Reset during RD_DATA, then a clean read from m[1].
      tb_arvalid[0] = 1'b1;
      tb_araddr[0]  = 32'h0000_7000;
      step();
      s_arready = 1'b1;
      step();
      tb_arvalid[0] = 1'b0;
      s_arready     = 1'b0;
      chk("rstmid_state_data", 32'(dut_state), 32'(ST_RD_DATA));
      s_rvalid = 1'b1;
      reset    = 1'b1;
      step();
      chk("rstmid_state", 32'(dut_state), 32'(ST_IDLE));
      chk("rstmid_s_valids", 32'({s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready}), 32'd0);
      chk("rstmid_m_outs", 32'({ob_arready, ob_rvalid, ob_awready, ob_wready, ob_bvalid}), 32'd0);
      s_rvalid = 1'b0;
      reset    = 1'b0;
      tb_arvalid[1] = 1'b1;
      tb_araddr[1]  = 32'h0000_9000;
      serve_read(1, 32'h0000_9000, 32'h1234_5678, AXI_RESP_OKAY, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
